// File: rtl/fe_test_pkg.sv
// Shared types and constants for the front-end test-pattern sequencer and its helpers.
package fe_test_pkg;

  // Divider terminal counts from mclk (49.152 MHz); strobe period is value + 1 clocks.
  localparam logic [10:0] SMP_DIV_192K = 11'h0FF;
  localparam logic [10:0] SMP_DIV_96K  = 11'h1FF;
  localparam logic [10:0] SMP_DIV_48K  = 11'h3FF;
  localparam logic [10:0] SMP_DIV_44K1 = 11'h45A;
  localparam logic [10:0] SMP_DIV_88K2 = 11'h22C;

  localparam int unsigned STEP_DWELL_W = 16;

  typedef enum logic [1:0] {
    FE_BYPASS   = 2'd0,
    FE_POS_DC   = 2'd1,
    FE_NEG_DC   = 2'd2,
    FE_TRIANGLE = 2'd3
  } fe_mode_e;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StRun,
    StNext,
    StFinish
  } seq_state_e;

  typedef struct packed {
    fe_mode_e                  mode;
    logic [7:0]                inc;
    logic [STEP_DWELL_W-1:0]   dwell;
  } step_t;

  function automatic logic [10:0] rate_div(input logic [2:0] sel);
    case (sel)
      3'd0:    return SMP_DIV_192K;
      3'd1:    return SMP_DIV_96K;
      3'd3:    return SMP_DIV_44K1;
      3'd4:    return SMP_DIV_88K2;
      default: return SMP_DIV_48K;
    endcase
  endfunction

endpackage

// File: rtl/fe_test_sequencer_if.sv
// Control/config bundle between the register bank (master) and the test sequencer (slave).
interface fe_test_sequencer_if #(
  parameter int unsigned NUM_STEPS = 4,
  parameter int unsigned DWELL_W   = 16
);
  localparam int unsigned IdxW = $clog2(NUM_STEPS);

  logic               start;
  logic               abort;
  logic [2:0]         rate_sel;
  logic               cfg_we;
  logic [IdxW-1:0]    cfg_addr;
  logic [1:0]         cfg_mode;
  logic [7:0]         cfg_inc;
  logic [DWELL_W-1:0] cfg_dwell;
  logic               fe_run;
  logic [1:0]         fe_select;
  logic [7:0]         fe_inc;
  logic               smp_strobe;
  logic               busy;
  logic               done;
  logic [IdxW-1:0]    step_idx;

  modport master (
    output start, abort, rate_sel, cfg_we, cfg_addr, cfg_mode, cfg_inc, cfg_dwell,
    input  fe_run, fe_select, fe_inc, smp_strobe, busy, done, step_idx
  );

  modport slave (
    input  start, abort, rate_sel, cfg_we, cfg_addr, cfg_mode, cfg_inc, cfg_dwell,
    output fe_run, fe_select, fe_inc, smp_strobe, busy, done, step_idx
  );

endinterface

// File: rtl/fe_smp_strobe_gen.sv
// Sample-rate divider: counts 0..div while enabled, registered one-cycle strobe at count == div.
module fe_smp_strobe_gen #(
  parameter int unsigned DIV_W = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             strobe
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             act_q;
  logic             strobe_q, strobe_d;

  // en describes the coming cycle; the first enabled cycle always starts at count 0.
  always_comb begin
    cnt_d = '0;
    if (en && act_q) begin
      cnt_d = (cnt_q == div) ? '0 : cnt_q + 1'b1;
    end
    strobe_d = en && (cnt_d == div);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      act_q    <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      act_q    <= en;
      strobe_q <= strobe_d;
    end
  end

  assign strobe = strobe_q;

endmodule

// File: rtl/fe_test_sequencer.sv
// Steps the front-end test generator through a programmed table of {mode, inc, dwell} entries.
module fe_test_sequencer
  import fe_test_pkg::*;
#(
  parameter int unsigned NUM_STEPS = 4,
  parameter int unsigned DWELL_W   = STEP_DWELL_W,  // must match the table entry width
  parameter int unsigned DIV_W     = 11
) (
  input logic                clk,
  input logic                reset,
  fe_test_sequencer_if.slave bus
);

  localparam int unsigned IdxW = $clog2(NUM_STEPS);

  seq_state_e         st_q, st_d;
  step_t              tbl_q [NUM_STEPS];
  logic [IdxW-1:0]    step_idx_q, step_idx_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d, dwell_inc;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               fe_run_q, fe_run_d;
  fe_mode_e           fe_select_q, fe_select_d;
  logic [7:0]         fe_inc_q, fe_inc_d;
  logic               busy_q, done_q, done_d;
  logic               smp_strobe, cnt_en;
  logic               hit_found;
  logic [IdxW-1:0]    hit_idx;
  int unsigned        search_base;

  // First entry at or above search_base with a non-zero dwell.
  always_comb begin
    search_base = (st_q == StArm) ? 0 : int'(step_idx_q) + 1;
    hit_found   = 1'b0;
    hit_idx     = '0;
    for (int unsigned i = 0; i < NUM_STEPS; i++) begin
      if (!hit_found && i >= search_base && tbl_q[i].dwell != '0) begin
        hit_found = 1'b1;
        hit_idx   = IdxW'(i);
      end
    end
  end

  assign dwell_inc = dwell_cnt_q + 1'b1;

  always_comb begin
    st_d        = st_q;
    step_idx_d  = step_idx_q;
    dwell_cnt_d = dwell_cnt_q;
    div_d       = div_q;
    fe_run_d    = fe_run_q;
    fe_select_d = fe_select_q;
    fe_inc_d    = fe_inc_q;
    done_d      = 1'b0;

    unique case (st_q)
      StIdle: begin
        if (bus.start && !bus.abort) begin
          st_d  = StArm;
          div_d = DIV_W'(rate_div(bus.rate_sel));
        end
      end
      StArm, StNext: begin
        dwell_cnt_d = '0;
        if (hit_found) begin
          st_d        = StRun;
          fe_run_d    = 1'b1;
          fe_select_d = tbl_q[hit_idx].mode;
          fe_inc_d    = tbl_q[hit_idx].inc;
          step_idx_d  = hit_idx;
        end else begin
          st_d = StFinish;
        end
      end
      StRun: begin
        if (smp_strobe) begin
          dwell_cnt_d = dwell_inc;
          if (dwell_inc == tbl_q[step_idx_q].dwell) begin
            st_d = StNext;
          end
        end
      end
      StFinish: st_d = StIdle;
      default:  st_d = StIdle;
    endcase

    if (bus.abort && st_q != StIdle) begin
      st_d = StIdle;
    end

    if (st_d == StIdle || st_d == StFinish) begin
      fe_run_d    = 1'b0;
      fe_select_d = FE_BYPASS;
      done_d      = (st_d == StFinish);
    end
    if (st_d == StIdle) begin
      step_idx_d  = '0;
      dwell_cnt_d = '0;
    end
  end

  assign cnt_en = (st_d == StRun) || (st_d == StNext);

  fe_smp_strobe_gen #(
    .DIV_W (DIV_W)
  ) u_strobe (
    .clk    (clk),
    .reset  (reset),
    .en     (cnt_en),
    .div    (div_q),
    .strobe (smp_strobe)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q        <= StIdle;
      step_idx_q  <= '0;
      dwell_cnt_q <= '0;
      div_q       <= '0;
      fe_run_q    <= 1'b0;
      fe_select_q <= FE_BYPASS;
      fe_inc_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      st_q        <= st_d;
      step_idx_q  <= step_idx_d;
      dwell_cnt_q <= dwell_cnt_d;
      div_q       <= div_d;
      fe_run_q    <= fe_run_d;
      fe_select_q <= fe_select_d;
      fe_inc_q    <= fe_inc_d;
      busy_q      <= (st_d != StIdle);
      done_q      <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_STEPS; i++) begin
        tbl_q[i] <= '0;
      end
    end else if (bus.cfg_we && !busy_q) begin
      tbl_q[bus.cfg_addr] <= '{mode:  fe_mode_e'(bus.cfg_mode),
                               inc:   bus.cfg_inc,
                               dwell: STEP_DWELL_W'(bus.cfg_dwell)};
    end
  end

  assign bus.fe_run     = fe_run_q;
  assign bus.fe_select  = fe_select_q;
  assign bus.fe_inc     = fe_inc_q;
  assign bus.smp_strobe = smp_strobe;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.step_idx   = step_idx_q;

endmodule

// File: tb/tb_fe_test_sequencer.sv
// Directed bench for fe_test_sequencer with cycle-exact hand-computed expectations.
module tb_fe_test_sequencer;

  localparam int MaxT = 3400;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic       run_log  [0:MaxT];
  logic [1:0] sel_log  [0:MaxT];
  logic [7:0] inc_log  [0:MaxT];
  logic [1:0] idx_log  [0:MaxT];
  logic       busy_log [0:MaxT];
  int         strobe_t [$];
  int         done_t   [$];

  fe_test_sequencer_if #(.NUM_STEPS(4), .DWELL_W(16)) bus ();

  fe_test_sequencer #(
    .NUM_STEPS (4),
    .DWELL_W   (16),
    .DIV_W     (11)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic write_entry(input int addr, input int mode, input int inc, input int dwell);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = 2'(addr);
    bus.cfg_mode  = 2'(mode);
    bus.cfg_inc   = 8'(inc);
    bus.cfg_dwell = 16'(dwell);
    tick();
    bus.cfg_we = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic log_at(input int t);
    run_log[t]  = bus.fe_run;
    sel_log[t]  = bus.fe_select;
    inc_log[t]  = bus.fe_inc;
    idx_log[t]  = bus.step_idx;
    busy_log[t] = bus.busy;
    if (bus.smp_strobe) strobe_t.push_back(t);
    if (bus.done) done_t.push_back(t);
  endtask

  // t = 0 is the cycle right after the edge that sampled start.
  task automatic run_record(input int max_t);
    strobe_t.delete();
    done_t.delete();
    log_at(0);
    for (int t = 1; t <= max_t; t++) begin
      tick();
      bus.cfg_we = 1'b0;
      log_at(t);
    end
  endtask

  task automatic check_strobes(input string tag, input int first, input int spacing, input int n);
    check({tag, "_count"}, strobe_t.size(), n);
    for (int k = 0; k < n && k < strobe_t.size(); k++) begin
      check({tag, "_time"}, strobe_t[k], first + k * spacing);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_run"}, bus.fe_run, 0);
    check({tag, "_sel"}, bus.fe_select, 0);
    check({tag, "_strobe"}, bus.smp_strobe, 0);
    check({tag, "_done"}, bus.done, 0);
  endtask

  task automatic load_main_table();
    write_entry(0, 3, 8'h15, 4);
    write_entry(1, 1, 0, 2);
    write_entry(2, 0, 0, 0);
    write_entry(3, 2, 0, 1);
  endtask

  initial begin
    int seen;
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.rate_sel  = 3'd0;
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_mode  = '0;
    bus.cfg_inc   = '0;
    bus.cfg_dwell = '0;
    tick();
    tick();
    check_idle_outputs("reset");
    check("reset_inc", bus.fe_inc, 0);
    check("reset_idx", bus.step_idx, 0);
    reset = 1'b0;
    tick();

    // Main table at 192k: steps 0 -> 1 -> 3, entry 2 skipped.
    load_main_table();
    bus.rate_sel = 3'd0;
    pulse_start();
    run_record(1800);
    check("t1_arm_busy", busy_log[0], 1);
    check("t1_arm_run", run_log[0], 0);
    check("t1_run_rise", run_log[1], 1);
    check("t1_sel0", sel_log[1], 3);
    check("t1_inc0", inc_log[1], 8'h15);
    check("t1_idx_before_next", idx_log[1025], 0);
    check("t1_idx1", idx_log[1026], 1);
    check("t1_sel1", sel_log[1026], 1);
    check("t1_inc1", inc_log[1026], 0);
    check("t1_idx3", idx_log[1538], 3);
    check("t1_sel3", sel_log[1538], 2);
    check_strobes("t1_strobe", 256, 256, 7);
    check("t1_done_count", done_t.size(), 1);
    if (done_t.size() > 0) check("t1_done_time", done_t[0], 1794);
    check("t1_finish_run", run_log[1794], 0);
    check("t1_finish_sel", sel_log[1794], 0);
    check("t1_busy_after", busy_log[1795], 0);

    // 44.1k single step, rate_sel changed mid-run must not matter.
    write_entry(0, 3, 8'h40, 3);
    write_entry(1, 1, 0, 0);
    write_entry(3, 2, 0, 0);
    bus.rate_sel = 3'd3;
    pulse_start();
    bus.rate_sel = 3'd0;
    run_record(3400);
    check_strobes("t2_strobe", 1115, 1115, 3);
    check("t2_done_count", done_t.size(), 1);
    if (done_t.size() > 0) check("t2_done_time", done_t[0], 3347);
    check("t2_busy_after", busy_log[3348], 0);

    // All dwell zero: ARM straight to FINISH.
    write_entry(0, 3, 8'h40, 0);
    pulse_start();
    run_record(4);
    seen = 0;
    for (int t = 0; t <= 4; t++) seen += int'(run_log[t]);
    check("t3_run_never", seen, 0);
    check("t3_done_count", done_t.size(), 1);
    if (done_t.size() > 0) check("t3_done_time", done_t[0], 1);
    check("t3_busy_after", busy_log[2], 0);

    // start and abort together while idle.
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("t3b_stay_idle", bus.busy, 0);

    // Abort mid-step 1.
    load_main_table();
    pulse_start();
    run_record(1300);
    check("t4_in_step1", idx_log[1300], 1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check_idle_outputs("t4_abort");
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      seen += int'(bus.done);
    end
    check("t4_no_done", seen, 0);

    // Replay from step 0; table write during the run must be ignored.
    pulse_start();
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = 2'd0;
    bus.cfg_mode  = 2'd0;
    bus.cfg_inc   = 8'd0;
    bus.cfg_dwell = 16'd9;
    run_record(1800);
    check("t5_replay_idx", idx_log[1], 0);
    check("t5_replay_sel", sel_log[1], 3);
    check("t5_idx1", idx_log[1026], 1);
    check("t5_done_count", done_t.size(), 1);
    if (done_t.size() > 0) check("t5_done_time", done_t[0], 1794);
    pulse_start();
    run_record(1800);
    check("t5_rb_idx0", idx_log[1025], 0);
    check("t5_rb_sel0", sel_log[1025], 3);
    check("t5_rb_idx1", idx_log[1026], 1);
    if (done_t.size() > 0) check("t5_rb_done_time", done_t[0], 1794);
    else check("t5_rb_done_count", done_t.size(), 1);

    // Synchronous reset mid-RUN clears everything including the table.
    pulse_start();
    run_record(300);
    check("t6_running", run_log[300], 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle_outputs("t6_reset");
    check("t6_reset_idx", bus.step_idx, 0);
    check("t6_reset_inc", bus.fe_inc, 0);
    pulse_start();
    run_record(3);
    check("t6_run_after", run_log[1], 0);
    check("t6_done_count", done_t.size(), 1);
    if (done_t.size() > 0) check("t6_done_time", done_t[0], 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
